lab3_cache_bypass_buf: RTL and testbench
========================================

// Module: lab3_cache_bypass_buf
// PURPOSE
//  Buffered, flow-controlled bypass between a processor mem port and a cache/memory port.
//  Decouples both directions with request and response FIFOs.
//  Caps requests in flight at the cache, so responses can never overflow the response FIFO.
//  Implements a real flush: drain everything, then a one-cycle flush_done pulse.
//  Drops in wherever the zero-latency combinational bypass was used (imem/dmem side of lab3 cache).
// PARAMETERS
//  p_req_depth       2  request FIFO entries (>=1)
//  p_resp_depth      2  response FIFO entries (>=1)
//  p_max_outstanding 4  max requests issued to the cache without a response (>=1)
// PORTS
//  clk             in   1              clock, all state updates on posedge
//  reset           in   1              synchronous, active-high
//  memreq_val      in   1              processor request valid
//  memreq_rdy      out  1              processor request ready
//  memreq_msg      in   mem_req_4B_t   processor request
//  memresp_val     out  1              processor response valid
//  memresp_rdy     in   1              processor response ready
//  memresp_msg     out  mem_resp_4B_t  processor response
//  cache_req_val   out  1              request to cache valid
//  cache_req_rdy   in   1              cache accepts request
//  cache_req_msg   out  mem_req_4B_t   request to cache
//  cache_resp_val  in   1              cache response valid
//  cache_resp_rdy  out  1              ready for cache response
//  cache_resp_msg  in   mem_resp_4B_t  cache response
//  flush           in   1              flush request, sampled only in RUN
//  flush_done      out  1              one-cycle pulse when drain completes
// BEHAVIOUR
//  Handshake: a transfer occurs when val && rdy on the same posedge. Messages pass through unmodified, in order.
//  Reset: both FIFOs empty, inflight = 0, state = RUN.
//   Resulting outputs: memreq_rdy = 1, memresp_val = 0, cache_req_val = 0, cache_resp_rdy = 1, flush_done = 0.
//   Reset asserted mid-operation discards all queued and in-flight state; late cache responses after reset are the environment's fault.
//  Latency: the FIFOs are registered, not bypassed.
//   A request accepted at cycle t appears on cache_req_* at t+1 at the earliest.
//   A response accepted at t appears on memresp_* at t+1 at the earliest.
//   Full throughput of 1 transfer/cycle in each direction when depth >= 2.
//  memreq_rdy = (state == RUN) && !reqq_full. A FIFO full at cycle start refuses enq even if deq occurs that cycle.
//  cache_req_val = !reqq_empty && (inflight < p_max_outstanding).
//  cache_resp_rdy = !respq_full.
//  memresp_val = !respq_empty.
//  inflight width: $clog2(p_max_outstanding+1).
//   +1 on cache_req fire, -1 on cache_resp fire, unchanged if both fire in the same cycle.
//   No wrap is possible by construction. Assert on underflow (response with inflight == 0).
//  FSM states RUN, DRAIN, DONE:
//   RUN: if flush, go to DRAIN. A request accepted in the same cycle flush is sampled is part of the drain.
//   DRAIN: memreq_rdy = 0. Outgoing requests and responses continue.
//    Go to DONE when reqq_empty && inflight == 0 && respq_empty.
//   DONE: flush_done = 1 for exactly this cycle, memreq_rdy = 0. Unconditionally return to RUN.
//   flush asserted in DRAIN or DONE is ignored (no queued second flush).
//   flush asserted with everything already empty: RUN, then DRAIN, then DONE. flush_done is high 2 cycles after flush.
// CONFIGURATION
//  LAB3_CACHE_BYPASS_STATS_EN defined adds outputs:
//   stat_req_count   out 32  requests accepted on memreq, wraps at 2^32
//   stat_flush_count out 32  completed flushes (DONE cycles), wraps
//   Both are cleared by reset.
//  Undefined: the ports and counters do not exist, and core behaviour is identical.
// STRUCTURE
//  Package lab3_cache_bypass_pkg: state enum {RUN, DRAIN, DONE}. mem_req_4B_t and mem_resp_4B_t stay from vc/mem-msgs.v.
//  Sub-module lab3_cache_bypass_fifo:
//   Type-agnostic width/depth params, circular buffer with ptrs and a count.
//   Provides enq_val/enq_rdy/deq_val/deq_rdy, registered output, no bypass.
//   Instantiated twice: request FIFO and response FIFO.
//  Top level holds the FSM, inflight counter and optional stats.
// TESTING
//  1. Stream 8 reads, addrs 0x1000..0x101C, cache always ready, 1-cycle response.
//     Expect 8 in-order responses with matching opaque; 1 request/cycle sustained after fill; first cache_req_val at t+1.
//  2. p_max_outstanding=4, cache never responds, 6 requests sent.
//     Expect exactly 4 cache_req fires; inflight == 4; cache_req_val low; memreq_rdy falls when reqq full.
//  3. memresp_rdy=0 with 3 responses returned, p_resp_depth=2.
//     Expect cache_resp_rdy = 0 after 2; releasing memresp_rdy delivers all 3 in order.
//  4. Flush with 3 requests in flight.
//     Expect memreq_rdy = 0 from next cycle; flush_done one-cycle pulse only after the last memresp fire; memreq_rdy = 1 the cycle after.
//  5. Flush while idle.
//     Expect flush_done high exactly 2 cycles later, for one cycle; flush re-pulsed during DRAIN yields no second flush_done.
//  6. Reset asserted in DRAIN with 2 queued requests.
//     Expect memresp_val = 0, cache_req_val = 0, flush_done = 0, memreq_rdy = 1 next cycle; with STATS_EN, both counters read 0.

Source files
------------

// File: rtl/lab3_cache_bypass_pkg.sv
// Shared types for the lab3 cache bypass buffer: memory message formats and drain FSM states.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package lab3_cache_bypass_pkg;

    // 4-byte memory request: type, opaque tag, address, length, write data.
    typedef struct packed {
        logic [2:0]  type_;
        logic [7:0]  opaque;
        logic [31:0] addr;
        logic [1:0]  len;
        logic [31:0] data;
    } mem_req_4B_t;

    // 4-byte memory response: type, opaque tag, test bits, length, read data.
    typedef struct packed {
        logic [2:0]  type_;
        logic [7:0]  opaque;
        logic [1:0]  test;
        logic [1:0]  len;
        logic [31:0] data;
    } mem_resp_4B_t;

    // Flush sequencing: normal operation, draining, one-cycle completion.
    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/lab3_cache_bypass_fifo.sv
// Generic circular-buffer FIFO with pointers and an occupancy count.
// Latency: 1 cycle enq-to-deq; output driven from storage, never bypassed.
// Backpressure: enq_rdy = not full at cycle start (a same-cycle deq does not free a slot).
module lab3_cache_bypass_fifo #(
    parameter int unsigned p_width = 8,
    parameter int unsigned p_depth = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enq_val,
    output logic               enq_rdy,
    input  logic [p_width-1:0] enq_msg,
    output logic               deq_val,
    input  logic               deq_rdy,
    output logic [p_width-1:0] deq_msg
);

    localparam int unsigned PW = (p_depth > 1) ? $clog2(p_depth) : 1;
    localparam int unsigned CW = $clog2(p_depth + 1);
    localparam logic [PW-1:0] LAST_PTR = PW'(p_depth - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(p_depth);

    logic [p_width-1:0] mem_q [p_depth];
    logic [p_width-1:0] mem_d [p_depth];
    logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]      count_q, count_d;
    logic               enq_fire;
    logic               deq_fire;

    assign enq_rdy  = (count_q != FULL_CNT);
    assign deq_val  = (count_q != '0);
    assign deq_msg  = mem_q[rd_ptr_q];
    assign enq_fire = enq_val && enq_rdy;
    assign deq_fire = deq_val && deq_rdy;

    // Next storage, pointer and occupancy state from this cycle's handshakes.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (enq_fire) begin
            mem_d[wr_ptr_q] = enq_msg;
            wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
        end
        if (deq_fire) begin
            rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
        end
        if (enq_fire && !deq_fire) begin
            count_d = count_q + 1'b1;
        end else if (!enq_fire && deq_fire) begin
            count_d = count_q - 1'b1;
        end
    end

    // FIFO state register; reset empties the queue.
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/lab3_cache_bypass_buf.sv
// Buffered processor<->cache bypass with request/response FIFOs, in-flight cap and drain-style flush.
// Latency: 1 cycle minimum per direction (registered FIFOs); 1 transfer/cycle sustained with depth >= 2.
// Backpressure: memreq_rdy drops on full request FIFO or during flush; issue stalls at p_max_outstanding.
// Optional: define LAB3_CACHE_BYPASS_STATS_EN for request/flush counter outputs.
module lab3_cache_bypass_buf
    import lab3_cache_bypass_pkg::*;
#(
    parameter int unsigned p_req_depth       = 2,
    parameter int unsigned p_resp_depth      = 2,
    parameter int unsigned p_max_outstanding = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         memreq_val,
    output logic         memreq_rdy,
    input  mem_req_4B_t  memreq_msg,
    output logic         memresp_val,
    input  logic         memresp_rdy,
    output mem_resp_4B_t memresp_msg,
    output logic         cache_req_val,
    input  logic         cache_req_rdy,
    output mem_req_4B_t  cache_req_msg,
    input  logic         cache_resp_val,
    output logic         cache_resp_rdy,
    input  mem_resp_4B_t cache_resp_msg,
    input  logic         flush,
    output logic         flush_done
`ifdef LAB3_CACHE_BYPASS_STATS_EN
    ,
    output logic [31:0]  stat_req_count,
    output logic [31:0]  stat_flush_count
`endif
);

    localparam int unsigned IW = $clog2(p_max_outstanding + 1);
    localparam logic [IW-1:0] MAX_INFLIGHT = IW'(p_max_outstanding);

    state_t        state_q, state_d;
    logic [IW-1:0] inflight_q, inflight_d;
    logic          reqq_enq_rdy;
    logic          reqq_deq_val;
    logic          issue_ok;
    logic          memreq_fire;
    logic          cache_req_fire;
    logic          cache_resp_fire;
    logic          drained;

    // Responses can only return for issued requests, so capping issue keeps the response FIFO safe.
    assign issue_ok        = (inflight_q < MAX_INFLIGHT);
    assign cache_req_val   = reqq_deq_val && issue_ok;
    assign memreq_fire     = memreq_val && memreq_rdy;
    assign cache_req_fire  = cache_req_val && cache_req_rdy;
    assign cache_resp_fire = cache_resp_val && cache_resp_rdy;
    assign drained         = !reqq_deq_val && (inflight_q == '0) && !memresp_val;

    lab3_cache_bypass_fifo #(
        .p_width ($bits(mem_req_4B_t)),
        .p_depth (p_req_depth)
    ) u_reqq (
        .clk     (clk),
        .reset   (reset),
        .enq_val (memreq_val && (state_q == RUN)),
        .enq_rdy (reqq_enq_rdy),
        .enq_msg (memreq_msg),
        .deq_val (reqq_deq_val),
        .deq_rdy (cache_req_rdy && issue_ok),
        .deq_msg (cache_req_msg)
    );

    lab3_cache_bypass_fifo #(
        .p_width ($bits(mem_resp_4B_t)),
        .p_depth (p_resp_depth)
    ) u_respq (
        .clk     (clk),
        .reset   (reset),
        .enq_val (cache_resp_val),
        .enq_rdy (cache_resp_rdy),
        .enq_msg (cache_resp_msg),
        .deq_val (memresp_val),
        .deq_rdy (memresp_rdy),
        .deq_msg (memresp_msg)
    );

    // Flush FSM: RUN accepts requests; DRAIN waits for all queues and the cache to empty; DONE pulses.
    always_comb begin
        state_d    = state_q;
        memreq_rdy = 1'b0;
        flush_done = 1'b0;
        case (state_q)
            RUN: begin
                memreq_rdy = reqq_enq_rdy;
                if (flush) state_d = DRAIN;
            end
            DRAIN: begin
                if (drained) state_d = DONE;
            end
            DONE: begin
                flush_done = 1'b1;
                state_d    = RUN;
            end
            default: state_d = RUN;
        endcase
    end

    // Outstanding-request count; simultaneous issue and return cancel out.
    always_comb begin
        inflight_d = inflight_q;
        if (cache_req_fire && !cache_resp_fire) begin
            inflight_d = inflight_q + 1'b1;
        end else if (!cache_req_fire && cache_resp_fire) begin
            inflight_d = inflight_q - 1'b1;
        end
    end

    // FSM and in-flight registers; reset drops any outstanding bookkeeping.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= RUN;
            inflight_q <= '0;
        end else begin
            state_q    <= state_d;
            inflight_q <= inflight_d;
        end
    end

    // A cache response with nothing outstanding means the environment broke the protocol.
    assert property (@(posedge clk) disable iff (reset) !(cache_resp_fire && (inflight_q == '0)));

`ifdef LAB3_CACHE_BYPASS_STATS_EN
    logic [31:0] stat_req_q, stat_req_d;
    logic [31:0] stat_flush_q, stat_flush_d;

    // Free-running wrap-around counters of accepted requests and completed flushes.
    always_comb begin
        stat_req_d   = stat_req_q + {31'd0, memreq_fire};
        stat_flush_d = stat_flush_q + {31'd0, flush_done};
    end

    // Statistics registers, cleared by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            stat_req_q   <= '0;
            stat_flush_q <= '0;
        end else begin
            stat_req_q   <= stat_req_d;
            stat_flush_q <= stat_flush_d;
        end
    end

    assign stat_req_count   = stat_req_q;
    assign stat_flush_count = stat_flush_q;
`endif

endmodule

// File: tb/tb_lab3_cache_bypass_buf.sv
// Bench for lab3_cache_bypass_buf: queue-level reference model checked every cycle plus directed scenarios.
// Latency: n/a.
// Backpressure: cache and processor ready/valid driven per scenario.
module tb_lab3_cache_bypass_buf;
    import lab3_cache_bypass_pkg::*;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         memreq_val = 1'b0;
    logic         memreq_rdy;
    mem_req_4B_t  memreq_msg = '0;
    logic         memresp_val;
    logic         memresp_rdy = 1'b1;
    mem_resp_4B_t memresp_msg;
    logic         cache_req_val;
    logic         cache_req_rdy = 1'b0;
    mem_req_4B_t  cache_req_msg;
    logic         cache_resp_val = 1'b0;
    logic         cache_resp_rdy;
    mem_resp_4B_t cache_resp_msg = '0;
    logic         flush = 1'b0;
    logic         flush_done;
`ifdef LAB3_CACHE_BYPASS_STATS_EN
    logic [31:0]  stat_req_count;
    logic [31:0]  stat_flush_count;
`endif

    lab3_cache_bypass_buf dut (
        .clk            (clk),
        .reset          (reset),
        .memreq_val     (memreq_val),
        .memreq_rdy     (memreq_rdy),
        .memreq_msg     (memreq_msg),
        .memresp_val    (memresp_val),
        .memresp_rdy    (memresp_rdy),
        .memresp_msg    (memresp_msg),
        .cache_req_val  (cache_req_val),
        .cache_req_rdy  (cache_req_rdy),
        .cache_req_msg  (cache_req_msg),
        .cache_resp_val (cache_resp_val),
        .cache_resp_rdy (cache_resp_rdy),
        .cache_resp_msg (cache_resp_msg),
        .flush          (flush),
        .flush_done     (flush_done)
`ifdef LAB3_CACHE_BYPASS_STATS_EN
        ,
        .stat_req_count   (stat_req_count),
        .stat_flush_count (stat_flush_count)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, want %0h", nm, act, exp);
        end
    endtask

    // ---------------- reference model (queues + drain mode) ----------------
    localparam int REQ_CAP  = 2;
    localparam int RESP_CAP = 2;
    localparam int MAX_OUT  = 4;

    mem_req_4B_t  mreq[$];
    mem_resp_4B_t mresp[$];
    int           minf  = 0;
    int           mmode = 0;  // 0 accepting, 1 draining, 2 completion pulse
    bit           mvalid = 1'b0;
    bit [31:0]    mst_req = 0;
    bit [31:0]    mst_fl = 0;
    bit           f_in, f_cq, f_cr, f_mr, m_empty;

    function automatic bit e_mrdy();  return (mmode == 0) && (mreq.size() < REQ_CAP); endfunction
    function automatic bit e_cqv();   return (mreq.size() > 0) && (minf < MAX_OUT);   endfunction
    function automatic bit e_crr();   return mresp.size() < RESP_CAP;                 endfunction
    function automatic bit e_mrv();   return mresp.size() > 0;                        endfunction

    always @(posedge clk) begin
        if (reset) begin
            mreq.delete();
            mresp.delete();
            minf    = 0;
            mmode   = 0;
            mst_req = 0;
            mst_fl  = 0;
            mvalid  = 1'b1;
        end else if (mvalid) begin
            f_in    = memreq_val && e_mrdy();
            f_cq    = e_cqv() && cache_req_rdy;
            f_cr    = cache_resp_val && e_crr();
            f_mr    = e_mrv() && memresp_rdy;
            m_empty = (mreq.size() == 0) && (minf == 0) && (mresp.size() == 0);
            if (mmode == 2) mst_fl++;
            if (mmode == 0) begin
                if (flush) mmode = 1;
            end else if (mmode == 1) begin
                if (m_empty) mmode = 2;
            end else begin
                mmode = 0;
            end
            if (f_cq) void'(mreq.pop_front());
            if (f_in) begin
                mreq.push_back(memreq_msg);
                mst_req++;
            end
            if (f_mr) void'(mresp.pop_front());
            if (f_cr) mresp.push_back(cache_resp_msg);
            minf = minf + int'(f_cq) - int'(f_cr);
        end
    end

    // Per-cycle comparison of every DUT output against the model.
    always @(negedge clk) begin
        if (mvalid) begin
            chk("cmp_memreq_rdy", memreq_rdy, e_mrdy());
            chk("cmp_cache_req_val", cache_req_val, e_cqv());
            if (e_cqv()) chk("cmp_cache_req_msg", cache_req_msg, mreq[0]);
            chk("cmp_cache_resp_rdy", cache_resp_rdy, e_crr());
            chk("cmp_memresp_val", memresp_val, e_mrv());
            if (e_mrv()) chk("cmp_memresp_msg", memresp_msg, mresp[0]);
            chk("cmp_flush_done", flush_done, mmode == 2);
`ifdef LAB3_CACHE_BYPASS_STATS_EN
            chk("cmp_stat_req", stat_req_count, mst_req);
            chk("cmp_stat_flush", stat_flush_count, mst_fl);
`endif
        end
    end

    // ---------------- environment ----------------
    mem_req_4B_t  sendq[$];
    mem_resp_4B_t pend[$];
    mem_resp_4B_t got[$];
    bit  cache_auto = 1'b0;
    int  cyc_n = 0;
    int  n_cq = 0, first_cq = -1, last_cq = -1, first_cqv = -1, first_in = -1;
    int  last_mr = -1, n_done = 0, done_cyc = -1;
    bit  s_mreq_rdy, s_creq_val, s_cresp_rdy, s_mresp_val, s_fd;

    function automatic mem_req_4B_t mk_req(input logic [31:0] addr, input logic [7:0] op);
        mem_req_4B_t r;
        r        = '0;
        r.addr   = addr;
        r.opaque = op;
        return r;
    endfunction

    function automatic mem_resp_4B_t resp_for(input mem_req_4B_t q);
        mem_resp_4B_t r;
        r        = '0;
        r.type_  = q.type_;
        r.opaque = q.opaque;
        r.data   = q.addr ^ 32'hA5A5_0000;
        return r;
    endfunction

    task automatic push_reqs(input logic [31:0] base, input logic [7:0] op0, input int n);
        for (int i = 0; i < n; i++) sendq.push_back(mk_req(base + 32'(4 * i), op0 + 8'(i)));
    endtask

    // One clock: observe at negedge, update drives just after posedge.
    task automatic cyc();
        bit w_in, w_cq, w_cr, w_mr;
        mem_req_4B_t cq_msg;
        @(negedge clk);
        s_mreq_rdy  = memreq_rdy;
        s_creq_val  = cache_req_val;
        s_cresp_rdy = cache_resp_rdy;
        s_mresp_val = memresp_val;
        s_fd        = flush_done;
        w_in = memreq_val && memreq_rdy;
        w_cq = cache_req_val && cache_req_rdy;
        w_cr = cache_resp_val && cache_resp_rdy;
        w_mr = memresp_val && memresp_rdy;
        cq_msg = cache_req_msg;
        if (w_in && first_in < 0) first_in = cyc_n;
        if (cache_req_val && first_cqv < 0) first_cqv = cyc_n;
        if (w_cq) begin
            n_cq++;
            if (first_cq < 0) first_cq = cyc_n;
            last_cq = cyc_n;
        end
        if (w_mr) begin
            got.push_back(memresp_msg);
            last_mr = cyc_n;
        end
        if (flush_done) begin
            n_done++;
            done_cyc = cyc_n;
        end
        @(posedge clk);
        #1;
        cyc_n++;
        if (w_in) void'(sendq.pop_front());
        if (w_cr) void'(pend.pop_front());
        if (cache_auto && w_cq) pend.push_back(resp_for(cq_msg));
        memreq_val = (sendq.size() > 0);
        if (sendq.size() > 0) memreq_msg = sendq[0];
        cache_resp_val = cache_auto && (pend.size() > 0);
        if (pend.size() > 0) cache_resp_msg = pend[0];
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic check_order(input string nm, input logic [31:0] base, input logic [7:0] op0, input int n);
        chk({nm, "_count"}, got.size(), n);
        for (int i = 0; i < n && i < got.size(); i++) begin
            chk({nm, "_opaque"}, got[i].opaque, op0 + 8'(i));
            chk({nm, "_data"}, got[i].data, (base + 32'(4 * i)) ^ 32'hA5A5_0000);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, want finish before 100000");
        $fatal(1);
    end

    initial begin
        run(2);
        reset = 1'b0;
        cyc();
        chk("rst_memreq_rdy", s_mreq_rdy, 1);
        chk("rst_memresp_val", s_mresp_val, 0);
        chk("rst_cache_req_val", s_creq_val, 0);
        chk("rst_cache_resp_rdy", s_cresp_rdy, 1);
        chk("rst_flush_done", s_fd, 0);

        // 1: stream of 8 reads, cache always ready with 1-cycle response
        cache_req_rdy = 1'b1;
        cache_auto    = 1'b1;
        first_in = -1; first_cqv = -1; first_cq = -1; n_cq = 0;
        got.delete();
        push_reqs(32'h1000, 8'h00, 8);
        run(25);
        chk("t1_first_cache_req_latency", first_cqv - first_in, 1);
        chk("t1_cache_req_fires", n_cq, 8);
        chk("t1_sustained_span", last_cq - first_cq, 7);
        check_order("t1", 32'h1000, 8'h00, 8);

        // 2: cache never responds; in-flight cap at 4
        cache_auto = 1'b0;
        n_cq = 0;
        got.delete();
        push_reqs(32'h2000, 8'h20, 6);
        run(15);
        chk("t2_cache_req_fires", n_cq, 4);
        chk("t2_cache_req_val_low", s_creq_val, 0);
        chk("t2_memreq_rdy_low", s_mreq_rdy, 0);
        chk("t2_all_accepted", sendq.size(), 0);
        for (int i = 0; i < 4; i++) pend.push_back(resp_for(mk_req(32'h2000 + 32'(4 * i), 8'h20 + 8'(i))));
        cache_auto = 1'b1;
        run(20);
        check_order("t2", 32'h2000, 8'h20, 6);

        // 3: processor stalls responses; response FIFO fills at 2
        got.delete();
        memresp_rdy = 1'b0;
        push_reqs(32'h3000, 8'h30, 3);
        run(12);
        chk("t3_cache_resp_rdy_low", s_cresp_rdy, 0);
        chk("t3_memresp_val_high", s_mresp_val, 1);
        chk("t3_nothing_delivered", got.size(), 0);
        memresp_rdy = 1'b1;
        run(10);
        check_order("t3", 32'h3000, 8'h30, 3);

        // 4: flush with 3 requests in flight
        cache_auto = 1'b0;
        n_cq = 0; n_done = 0;
        got.delete();
        push_reqs(32'h4000, 8'h40, 3);
        run(6);
        chk("t4_in_flight", n_cq, 3);
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        cyc();
        chk("t4_memreq_rdy_low", s_mreq_rdy, 0);
        run(3);
        chk("t4_no_early_done", n_done, 0);
        for (int i = 0; i < 3; i++) pend.push_back(resp_for(mk_req(32'h4000 + 32'(4 * i), 8'h40 + 8'(i))));
        cache_auto = 1'b1;
        for (int i = 0; i < 20 && !s_fd; i++) cyc();
        chk("t4_done_seen", s_fd, 1);
        chk("t4_done_after_resp", done_cyc > last_mr, 1);
        chk("t4_done_timing", done_cyc - last_mr, 2);
        check_order("t4", 32'h4000, 8'h40, 3);
        cyc();
        chk("t4_memreq_rdy_back", s_mreq_rdy, 1);
        chk("t4_done_one_cycle", s_fd, 0);

        // 5: flush while idle, re-pulsed during DRAIN and DONE
        n_done = 0;
        run(2);
        flush = 1'b1;
        cyc();
        chk("t5_fd_t0", s_fd, 0);
        cyc();
        chk("t5_fd_t1", s_fd, 0);
        cyc();
        chk("t5_fd_t2", s_fd, 1);
        flush = 1'b0;
        cyc();
        chk("t5_fd_t3", s_fd, 0);
        run(4);
        chk("t5_single_done", n_done, 1);

        // 6: reset asserted in DRAIN with 2 queued requests
        cache_req_rdy = 1'b0;
        cache_auto    = 1'b0;
        push_reqs(32'h6000, 8'h60, 2);
        run(4);
        chk("t6_reqq_full", s_mreq_rdy, 0);
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        run(3);
        chk("t6_stuck_drain_rdy", s_mreq_rdy, 0);
        chk("t6_stuck_drain_fd", s_fd, 0);
`ifdef LAB3_CACHE_BYPASS_STATS_EN
        chk("t6_stat_req_pre", stat_req_count, 22);
        chk("t6_stat_flush_pre", stat_flush_count, 2);
`endif
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        cyc();
        chk("t6_memresp_val", s_mresp_val, 0);
        chk("t6_cache_req_val", s_creq_val, 0);
        chk("t6_flush_done", s_fd, 0);
        chk("t6_memreq_rdy", s_mreq_rdy, 1);
`ifdef LAB3_CACHE_BYPASS_STATS_EN
        chk("t6_stat_req_clr", stat_req_count, 0);
        chk("t6_stat_flush_clr", stat_flush_count, 0);
`endif
        run(3);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
